// File: rtl/blob_stats_pkg.sv
// Shared types for blob_stats: FSM states, default widths and the drained record layout.
// The optional centroid sums are compiled in when BLOB_STATS_CENTROID_EN is defined.
package blob_stats_pkg;
  localparam int DEF_LABEL_W    = 8;
  localparam int DEF_NUM_LABELS = 256;
  localparam int DEF_COORD_W    = 16;
  localparam int DEF_AREA_W     = 20;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    INIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_LABEL_W-1:0] label;
    logic [DEF_COORD_W-1:0] xmin;
    logic [DEF_COORD_W-1:0] xmax;
    logic [DEF_COORD_W-1:0] ymin;
    logic [DEF_COORD_W-1:0] ymax;
    logic [DEF_AREA_W-1:0]  area;
`ifdef BLOB_STATS_CENTROID_EN
    logic [DEF_COORD_W+DEF_AREA_W-1:0] sum_x;
    logic [DEF_COORD_W+DEF_AREA_W-1:0] sum_y;
`endif
  } rec_t;

  // Empty entry: mins at all-ones so the first pixel always wins the compare.
  function automatic rec_t entry_rst();
    rec_t r;
    r      = '0;
    r.xmin = '1;
    r.ymin = '1;
    return r;
  endfunction
endpackage

// File: rtl/blob_stats_table.sv
// Per-label statistics storage with a read / update-write pipeline and a clear port.
// Optional sum_x/sum_y columns are compiled in with BLOB_STATS_CENTROID_EN.
module blob_stats_table
  import blob_stats_pkg::*;
#(
  parameter int LABEL_W    = DEF_LABEL_W,
  parameter int NUM_LABELS = DEF_NUM_LABELS,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int AREA_W     = DEF_AREA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               acc_valid,
  input  logic [LABEL_W-1:0] acc_label,
  input  logic [COORD_W-1:0] acc_x,
  input  logic [COORD_W-1:0] acc_y,
  input  logic               clr_valid,
  input  logic [LABEL_W-1:0] clr_idx,
  input  logic [LABEL_W-1:0] rd_idx,
  output logic [AREA_W-1:0]  rd_area,
  output logic [COORD_W-1:0] rd_xmin,
  output logic [COORD_W-1:0] rd_xmax,
  output logic [COORD_W-1:0] rd_ymin,
  output logic [COORD_W-1:0] rd_ymax
`ifdef BLOB_STATS_CENTROID_EN
  ,
  output logic [COORD_W+AREA_W-1:0] rd_sum_x,
  output logic [COORD_W+AREA_W-1:0] rd_sum_y
`endif
);
  typedef struct packed {
    logic [AREA_W-1:0]  area;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
`ifdef BLOB_STATS_CENTROID_EN
    logic [COORD_W+AREA_W-1:0] sum_x;
    logic [COORD_W+AREA_W-1:0] sum_y;
`endif
  } entry_t;

  entry_t             mem [NUM_LABELS];
  entry_t             ent_rst;
  entry_t             s1_ent;
  entry_t             upd;
  entry_t             rd_ent;
  logic               s1_valid;
  logic [LABEL_W-1:0] s1_label;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;

  always_comb begin
    ent_rst      = '0;
    ent_rst.xmin = '1;
    ent_rst.ymin = '1;
  end

  // Stage 2: fold the pixel held in stage 1 into the entry read for it.
  always_comb begin
    upd = s1_ent;
    if (s1_ent.area != '1) begin
      upd.area = s1_ent.area + AREA_W'(1);
`ifdef BLOB_STATS_CENTROID_EN
      upd.sum_x = s1_ent.sum_x + (COORD_W+AREA_W)'(s1_x);
      upd.sum_y = s1_ent.sum_y + (COORD_W+AREA_W)'(s1_y);
`endif
    end
    if (s1_x < s1_ent.xmin) upd.xmin = s1_x;
    if (s1_x > s1_ent.xmax) upd.xmax = s1_x;
    if (s1_y < s1_ent.ymin) upd.ymin = s1_y;
    if (s1_y > s1_ent.ymax) upd.ymax = s1_y;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_label <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_ent   <= ent_rst;
      for (int i = 0; i < NUM_LABELS; i++) mem[i] <= ent_rst;
    end else begin
      s1_valid <= acc_valid;
      if (acc_valid) begin
        s1_label <= acc_label;
        s1_x     <= acc_x;
        s1_y     <= acc_y;
        // The write of the previous pixel lands on this same edge, so a
        // same-label read has to take the freshly computed value instead.
        s1_ent   <= (s1_valid && s1_label == acc_label) ? upd : mem[acc_label];
      end
      if (s1_valid) mem[s1_label] <= upd;
      if (clr_valid) mem[clr_idx] <= ent_rst;
    end
  end

  assign rd_ent  = mem[rd_idx];
  assign rd_area = rd_ent.area;
  assign rd_xmin = rd_ent.xmin;
  assign rd_xmax = rd_ent.xmax;
  assign rd_ymin = rd_ent.ymin;
  assign rd_ymax = rd_ent.ymax;
`ifdef BLOB_STATS_CENTROID_EN
  assign rd_sum_x = rd_ent.sum_x;
  assign rd_sum_y = rd_ent.sum_y;
`endif
endmodule

// File: rtl/blob_stats.sv
// Per-label bounding box / area accumulator that drains one record per non-empty label on vsync.
// BLOB_STATS_CENTROID_EN adds out_sum_x/out_sum_y centroid accumulators.
module blob_stats
  import blob_stats_pkg::*;
#(
  parameter int LABEL_W    = DEF_LABEL_W,
  parameter int NUM_LABELS = DEF_NUM_LABELS,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int AREA_W     = DEF_AREA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [LABEL_W-1:0] label,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [COORD_W-1:0] out_xmin,
  output logic [COORD_W-1:0] out_xmax,
  output logic [COORD_W-1:0] out_ymin,
  output logic [COORD_W-1:0] out_ymax,
  output logic [AREA_W-1:0]  out_area,
`ifdef BLOB_STATS_CENTROID_EN
  output logic [COORD_W+AREA_W-1:0] out_sum_x,
  output logic [COORD_W+AREA_W-1:0] out_sum_y,
`endif
  output logic               busy,
  output logic               frame_drop,
  output state_t             state_dbg
);
  // Output handshake: a record transfers on a cycle with out_valid && out_ready;
  // while out_valid is high and out_ready low every out_* field holds still.
  localparam logic [LABEL_W:0] IDX_END = (LABEL_W+1)'(NUM_LABELS);

  state_t             state;
  state_t             state_nxt;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [LABEL_W:0]   idx;
  logic               acc_valid;
  logic               clr_valid;
  logic [LABEL_W-1:0] clr_idx;
  logic               can_advance;
  logic               idx_done;
  logic               load;
  logic [AREA_W-1:0]  rd_area;
  logic [COORD_W-1:0] rd_xmin;
  logic [COORD_W-1:0] rd_xmax;
  logic [COORD_W-1:0] rd_ymin;
  logic [COORD_W-1:0] rd_ymax;
`ifdef BLOB_STATS_CENTROID_EN
  logic [COORD_W+AREA_W-1:0] rd_sum_x;
  logic [COORD_W+AREA_W-1:0] rd_sum_y;
`endif

  assign acc_valid   = (state == ACCUM) && en && !hsync && !vsync && (label != '0);
  assign can_advance = !out_valid || out_ready;
  assign idx_done    = (idx == IDX_END);
  assign busy        = (state != ACCUM);
  assign state_dbg   = state;

  always_comb begin
    state_nxt = state;
    clr_valid = 1'b0;
    clr_idx   = out_label;
    load      = 1'b0;
    case (state)
      ACCUM: if (!hsync && vsync) state_nxt = DRAIN;
      // Each advancing cycle retires the presented record and examines label idx.
      DRAIN: if (can_advance) begin
        clr_valid = out_valid;
        if (idx_done) state_nxt = CLEAR;
        else          load      = (rd_area != '0);
      end
      CLEAR: begin
        clr_valid = 1'b1;
        clr_idx   = '0;
        state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ACCUM;
      x          <= '0;
      y          <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_label  <= '0;
      out_xmin   <= '0;
      out_xmax   <= '0;
      out_ymin   <= '0;
      out_ymax   <= '0;
      out_area   <= '0;
`ifdef BLOB_STATS_CENTROID_EN
      out_sum_x  <= '0;
      out_sum_y  <= '0;
`endif
      frame_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      if (busy && en) frame_drop <= 1'b1;
      if (state == ACCUM) begin
        if (hsync) begin
          x <= '0;
          y <= y + COORD_W'(1);
        end else if (vsync) begin
          x   <= '0;
          y   <= '0;
          idx <= (LABEL_W+1)'(1);
        end else if (en) begin
          x <= x + COORD_W'(1);
        end
      end
      if (state == DRAIN && can_advance) begin
        out_valid <= load;
        if (!idx_done) idx <= idx + (LABEL_W+1)'(1);
        if (load) begin
          out_label <= idx[LABEL_W-1:0];
          out_xmin  <= rd_xmin;
          out_xmax  <= rd_xmax;
          out_ymin  <= rd_ymin;
          out_ymax  <= rd_ymax;
          out_area  <= rd_area;
`ifdef BLOB_STATS_CENTROID_EN
          out_sum_x <= rd_sum_x;
          out_sum_y <= rd_sum_y;
`endif
        end
      end
    end
  end

  blob_stats_table #(
    .LABEL_W    (LABEL_W),
    .NUM_LABELS (NUM_LABELS),
    .COORD_W    (COORD_W),
    .AREA_W     (AREA_W)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_valid (acc_valid),
    .acc_label (label),
    .acc_x     (x),
    .acc_y     (y),
    .clr_valid (clr_valid),
    .clr_idx   (clr_idx),
    .rd_idx    (idx[LABEL_W-1:0]),
    .rd_area   (rd_area),
    .rd_xmin   (rd_xmin),
    .rd_xmax   (rd_xmax),
    .rd_ymin   (rd_ymin),
`ifdef BLOB_STATS_CENTROID_EN
    .rd_sum_x  (rd_sum_x),
    .rd_sum_y  (rd_sum_y),
`endif
    .rd_ymax   (rd_ymax)
  );
endmodule

// File: tb/tb_blob_stats.sv
// Directed bench for blob_stats: a default instance plus a second one with AREA_W=4
// sharing the same stimulus, used to observe area saturation.
module tb_blob_stats;
  import blob_stats_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [7:0]  label = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, busy, frame_drop;
  logic [7:0]  out_label;
  logic [15:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [19:0] out_area;
  state_t      state_dbg;

  logic        s_out_valid, s_busy, s_frame_drop;
  logic [7:0]  s_out_label;
  logic [15:0] s_out_xmin, s_out_xmax, s_out_ymin, s_out_ymax;
  logic [3:0]  s_out_area;
  state_t      s_state_dbg;
`ifdef BLOB_STATS_CENTROID_EN
  logic [35:0] out_sum_x, out_sum_y;
  logic [19:0] s_out_sum_x, s_out_sum_y;
`endif

  rec_t exp_q[$];
  rec_t got_q[$];
  rec_t sat_q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cycles, stall_cycles, hold_viol;
  bit   drain_timeout;

  always #5 clk = ~clk;

  blob_stats dut (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
    .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
    .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .out_area(out_area),
`ifdef BLOB_STATS_CENTROID_EN
    .out_sum_x(out_sum_x), .out_sum_y(out_sum_y),
`endif
    .busy(busy), .frame_drop(frame_drop), .state_dbg(state_dbg)
  );

  blob_stats #(.AREA_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_label(s_out_label),
    .out_xmin(s_out_xmin), .out_xmax(s_out_xmax), .out_ymin(s_out_ymin), .out_ymax(s_out_ymax),
    .out_area(s_out_area),
`ifdef BLOB_STATS_CENTROID_EN
    .out_sum_x(s_out_sum_x), .out_sum_y(s_out_sum_y),
`endif
    .busy(s_busy), .frame_drop(s_frame_drop), .state_dbg(s_state_dbg)
  );

  function automatic rec_t mk_rec(input int l, input int x0, input int x1,
                                  input int y0, input int y1, input int a);
    rec_t r;
    r       = '0;
    r.label = 8'(l);
    r.xmin  = 16'(x0);
    r.xmax  = 16'(x1);
    r.ymin  = 16'(y0);
    r.ymax  = 16'(y1);
    r.area  = 20'(a);
    return r;
  endfunction

  function automatic rec_t main_rec();
    rec_t r;
    r       = '0;
    r.label = out_label;
    r.xmin  = out_xmin;
    r.xmax  = out_xmax;
    r.ymin  = out_ymin;
    r.ymax  = out_ymax;
    r.area  = out_area;
    return r;
  endfunction

  function automatic rec_t sat_rec();
    rec_t r;
    r       = '0;
    r.label = s_out_label;
    r.xmin  = s_out_xmin;
    r.xmax  = s_out_xmax;
    r.ymin  = s_out_ymin;
    r.ymax  = s_out_ymax;
    r.area  = {16'b0, s_out_area};
    return r;
  endfunction

  // ---- driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic cycle(input logic h, input logic v, input logic e, input logic [7:0] l);
    @(negedge clk);
    hsync = h;
    vsync = v;
    en    = e;
    label = l;
  endtask

  // Pulse vsync, then run the drain to completion, logging accepted records.
  task automatic run_drain(input int stall, input int drop_n);
    int   cyc;
    bit   prev_hold;
    rec_t cur, prev;
    got_q.delete();
    sat_q.delete();
    busy_cycles   = 0;
    stall_cycles  = 0;
    hold_viol     = 0;
    drain_timeout = 1'b0;
    cyc           = 0;
    prev_hold     = 1'b0;
    prev          = '0;
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
    out_ready = 1'b0;
    while (1) begin
      @(negedge clk);
      vsync     = 1'b0;
      en        = (cyc < drop_n);
      label     = en ? 8'd2 : 8'd0;
      out_ready = (cyc >= stall);
      if (!busy) break;
      busy_cycles++;
      cur = main_rec();
      if (prev_hold && (!out_valid || cur != prev)) hold_viol++;
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && out_ready) got_q.push_back(cur);
      if (s_out_valid && out_ready) sat_q.push_back(sat_rec());
      prev_hold = out_valid && !out_ready;
      prev      = cur;
      cyc++;
      if (cyc > 3000) begin
        drain_timeout = 1'b1;
        break;
      end
    end
    en        = 1'b0;
    label     = 8'd0;
    out_ready = 1'b0;
  endtask

  // ---- scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL reset_frame_drop: got %b exp 0", frame_drop); end
    checks++; if (out_area !== 20'd0) begin failures++; $display("FAIL reset_out_area: got %0d exp 0", out_area); end
    checks++; if (out_xmin !== 16'd0) begin failures++; $display("FAIL reset_out_xmin: got %0d exp 0", out_xmin); end
    checks++; if (state_dbg !== ACCUM) begin failures++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, ACCUM); end
  endtask

  task automatic test_square();
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 4; xx++)
        cycle(1'b0, 1'b0, 1'b1, (xx >= 1 && xx <= 2 && yy >= 1 && yy <= 2) ? 8'd3 : 8'd0);
      cycle(1'b1, 1'b0, 1'b0, 8'd0);
    end
    run_drain(0, 0);
    exp_q.delete();
    exp_q.push_back(mk_rec(3, 1, 2, 1, 2, 4));
    checks++; if (drain_timeout !== 1'b0) begin failures++; $display("FAIL square_busy_fall: busy still high after bound"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL square_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL square_rec%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (busy_cycles > 257 + stall_cycles) begin failures++; $display("FAIL square_latency: got %0d exp <= %0d", busy_cycles, 257 + stall_cycles); end
    checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL square_frame_drop: got %b exp 0", frame_drop); end
  endtask

  task automatic test_back_to_back();
    for (int xx = 0; xx < 10; xx++) cycle(1'b0, 1'b0, 1'b1, 8'd5);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd6);
    cycle(1'b0, 1'b0, 1'b1, 8'd6);
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd6);
    run_drain(0, 0);
    exp_q.delete();
    exp_q.push_back(mk_rec(5, 0, 9, 0, 0, 10));
    exp_q.push_back(mk_rec(6, 0, 3, 1, 1, 3));
    checks++; if (drain_timeout !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: busy still high after bound"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_rec%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 1'b0, 1'b1, 8'd7);
    cycle(1'b0, 1'b0, 1'b1, 8'd2);
    cycle(1'b0, 1'b0, 1'b1, 8'd2);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd7);
    run_drain(20, 0);
    exp_q.delete();
    exp_q.push_back(mk_rec(2, 1, 2, 0, 0, 2));
    exp_q.push_back(mk_rec(7, 0, 1, 0, 1, 2));
    checks++; if (drain_timeout !== 1'b0) begin failures++; $display("FAIL bp_busy_fall: busy still high after bound"); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_rec%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_cycles === 0) begin failures++; $display("FAIL bp_stalled: got %0d stall cycles exp > 0", stall_cycles); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL bp_hold_stable: got %0d changes exp 0", hold_viol); end
    checks++; if (busy_cycles > 257 + stall_cycles) begin failures++; $display("FAIL bp_latency: got %0d exp <= %0d", busy_cycles, 257 + stall_cycles); end
  endtask

  task automatic test_saturation();
    for (int xx = 0; xx < 20; xx++) cycle(1'b0, 1'b0, 1'b1, 8'd1);
    run_drain(0, 0);
    checks++; if (sat_q.size() !== 1) begin failures++; $display("FAIL sat_count: got %0d exp 1", sat_q.size()); end
    if (sat_q.size() > 0) begin
      checks++; if (sat_q[0] !== mk_rec(1, 0, 19, 0, 0, 15)) begin failures++; $display("FAIL sat_rec: got %h exp %h", sat_q[0], mk_rec(1, 0, 19, 0, 0, 15)); end
    end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL nosat_count: got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== mk_rec(1, 0, 19, 0, 0, 20)) begin failures++; $display("FAIL nosat_rec: got %h exp %h", got_q[0], mk_rec(1, 0, 19, 0, 0, 20)); end
    end
  endtask

  task automatic test_drop_and_clear();
    for (int xx = 0; xx < 3; xx++) cycle(1'b0, 1'b0, 1'b1, 8'd9);
    run_drain(0, 3);
    checks++; if (frame_drop !== 1'b1) begin failures++; $display("FAIL drop_flag: got %b exp 1", frame_drop); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL drop_count: got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== mk_rec(9, 0, 2, 0, 0, 3)) begin failures++; $display("FAIL drop_rec: got %h exp %h", got_q[0], mk_rec(9, 0, 2, 0, 0, 3)); end
    end
    cycle(1'b0, 1'b0, 1'b1, 8'd2);
    run_drain(0, 0);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL clean_count: got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== mk_rec(2, 0, 0, 0, 0, 1)) begin failures++; $display("FAIL clean_rec: got %h exp %h", got_q[0], mk_rec(2, 0, 0, 0, 0, 1)); end
    end
    checks++; if (frame_drop !== 1'b1) begin failures++; $display("FAIL drop_sticky: got %b exp 1", frame_drop); end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    cycle(1'b0, 1'b0, 1'b1, 8'd4);
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    vsync     = 1'b0;
    en        = 1'b0;
    label     = 8'd0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_drain_valid: got %b exp 1", out_valid); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b exp 0", busy); end
    checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL mid_reset_drop: got %b exp 0", frame_drop); end
    run_drain(0, 0);
    checks++; if (drain_timeout !== 1'b0) begin failures++; $display("FAIL empty_busy_fall: busy still high after bound"); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL empty_count: got %0d exp 0", got_q.size()); end
    checks++; if (sat_q.size() !== 0) begin failures++; $display("FAIL empty_sat_count: got %0d exp 0", sat_q.size()); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_drop_and_clear();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
